// File: rtl/stq_pkg.sv
// Shared definitions for the path stack/queue: operating mode encoding and
// the count/pointer width helper.
package stq_pkg;

  typedef enum logic {
    MODE_STACK = 1'b0,
    MODE_QUEUE = 1'b1
  } stq_mode_e;

  // Count must represent 0..depth inclusive, hence depth+1 codes.
  function automatic int unsigned stq_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/path_stack_queue_if.sv
// Control/status bundle between the maze solver (master) and the path store (slave).
interface path_stack_queue_if
  import stq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
);

  localparam int unsigned CNT_W = stq_cnt_w(DEPTH);

  logic              clear;
  logic              push;
  logic              pop;
  logic              run;
  logic              done;
  logic              rewind;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              mode;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output clear, push, pop, run, done, rewind, din,
    input  dout, dout_valid, mode, count, empty, full, overflow, underflow
  );

  modport slave (
    input  clear, push, pop, run, done, rewind, din,
    output dout, dout_valid, mode, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/stq_mem.sv
// Path storage array: synchronous write, combinational read feeding the
// parent's registered output.
module stq_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/path_stack_queue.sv
// LIFO path store during search; after done it replays the surviving path
// oldest-first, non-destructively, with rewind and sticky error flags.
module path_stack_queue
  import stq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned CNT_W  = stq_cnt_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  path_stack_queue_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);

  stq_mode_e         r_mode;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_blocked;
  logic              w_s_pop;
  logic              w_s_push;
  logic              w_q_pop;
  logic              w_rd_en;
  logic              w_ovf_set;
  logic              w_udf_set;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] w_rdata;
  logic [CNT_W-1:0]  w_top;

  always_comb begin
    w_full    = (r_count == CntFull);
    w_empty   = (r_mode == MODE_QUEUE) ? (r_rd_ptr == r_count) : (r_count == '0);
    w_top     = r_count - CntOne;
    // clear, done and a queue-mode rewind all suppress the data operations
    w_blocked = bus.clear | bus.done | ((r_mode == MODE_QUEUE) & bus.rewind);

    w_s_pop   = (r_mode == MODE_STACK) & bus.pop & ~w_empty;
    // A simultaneous pop frees the top slot, so a full stack still takes the push.
    w_s_push  = (r_mode == MODE_STACK) & bus.push & (~w_full | w_s_pop);
    w_q_pop   = (r_mode == MODE_QUEUE) & bus.pop & bus.run & ~w_empty;
    w_rd_en   = w_s_pop | w_q_pop;

    w_ovf_set = bus.push & ((r_mode == MODE_QUEUE) | ~w_s_push);
    w_udf_set = bus.pop & w_empty & ((r_mode == MODE_STACK) | bus.run);

    w_we      = w_s_push & ~w_blocked;
    w_waddr   = w_s_pop ? AW'(w_top) : AW'(r_count);
    w_raddr   = (r_mode == MODE_QUEUE) ? AW'(r_rd_ptr) : AW'(w_top);
  end

  stq_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (bus.din),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode       <= MODE_STACK;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (bus.clear) begin
        r_mode      <= MODE_STACK;
        r_count     <= '0;
        r_rd_ptr    <= '0;
        r_dout      <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else if (bus.done) begin
        r_mode   <= MODE_QUEUE;
        r_rd_ptr <= '0;
      end else if ((r_mode == MODE_QUEUE) && bus.rewind) begin
        r_rd_ptr <= '0;
      end else begin
        if (w_rd_en) begin
          r_dout       <= w_rdata;
          r_dout_valid <= 1'b1;
        end
        if (w_q_pop) begin
          r_rd_ptr <= r_rd_ptr + CntOne;
        end
        if (w_s_push && !w_s_pop) begin
          r_count <= r_count + CntOne;
        end else if (w_s_pop && !w_s_push) begin
          r_count <= w_top;
        end
        if (w_ovf_set) begin
          r_overflow <= 1'b1;
        end
        if (w_udf_set) begin
          r_underflow <= 1'b1;
        end
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.mode       = r_mode;
  assign bus.count      = r_count;
  assign bus.empty      = w_empty;
  assign bus.full       = w_full;
  assign bus.overflow   = r_overflow;
  assign bus.underflow  = r_underflow;

endmodule

// File: tb/tb_path_stack_queue.sv
// Scoreboard bench: a queue-based path model predicts read data and status;
// a monitor pops expected words whenever dout_valid is seen.
module tb_path_stack_queue;
  import stq_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  path_stack_queue_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  path_stack_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] m_stk [$];
  bit         m_mode;
  int         m_rd;
  bit         m_ovf;
  bit         m_udf;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_stk.delete();
    m_mode = 1'b0;
    m_rd   = 0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endfunction

  // Path semantics: stack is a list with the top at the end; replay walks it from the front.
  function automatic void model_step(input bit clr, input bit dn, input bit rw, input bit ps,
                                     input bit pp, input bit rn, input logic [7:0] d);
    if (clr) begin
      model_reset();
    end else if (dn) begin
      m_mode = 1'b1;
      m_rd   = 0;
    end else if (m_mode && rw) begin
      m_rd = 0;
    end else if (!m_mode) begin
      if (ps && pp && m_stk.size() > 0) begin
        exp_q.push_back(m_stk[m_stk.size()-1]);
        m_stk[m_stk.size()-1] = d;
      end else begin
        if (pp) begin
          if (m_stk.size() == 0) m_udf = 1'b1;
          else exp_q.push_back(m_stk.pop_back());
        end
        if (ps) begin
          if (m_stk.size() == DEPTH) m_ovf = 1'b1;
          else m_stk.push_back(d);
        end
      end
    end else begin
      if (ps) m_ovf = 1'b1;
      if (pp && rn) begin
        if (m_rd < m_stk.size()) begin
          exp_q.push_back(m_stk[m_rd]);
          m_rd++;
        end else begin
          m_udf = 1'b1;
        end
      end
    end
  endfunction

  task automatic check_status();
    chk("count", int'(bus.count), m_stk.size());
    chk("empty", int'(bus.empty), m_mode ? int'(m_rd == m_stk.size()) : int'(m_stk.size() == 0));
    chk("full", int'(bus.full), int'(m_stk.size() == DEPTH));
    chk("mode", int'(bus.mode), int'(m_mode));
    chk("overflow", int'(bus.overflow), int'(m_ovf));
    chk("underflow", int'(bus.underflow), int'(m_udf));
  endtask

  task automatic drive_idle();
    bus.clear  = 1'b0;
    bus.push   = 1'b0;
    bus.pop    = 1'b0;
    bus.run    = 1'b0;
    bus.done   = 1'b0;
    bus.rewind = 1'b0;
    bus.din    = '0;
  endtask

  task automatic cycle(input bit clr, input bit dn, input bit rw, input bit ps, input bit pp,
                       input bit rn, input logic [7:0] d);
    @(negedge clk);
    bus.clear  = clr;
    bus.done   = dn;
    bus.rewind = rw;
    bus.push   = ps;
    bus.pop    = pp;
    bus.run    = rn;
    bus.din    = d;
    model_step(clr, dn, rw, ps, pp, rn, d);
    @(posedge clk);
    #1;
    check_status();
    drive_idle();
  endtask

  task automatic push_v(input logic [7:0] d);
    cycle(0, 0, 0, 1, 0, 0, d);
  endtask

  task automatic pop_v(input bit rn);
    cycle(0, 0, 0, 0, 1, rn, 8'h00);
  endtask

  // Monitor: every observed dout_valid must match the oldest predicted read.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.dout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL dout_unexpected: got 0x%0h, expected no read at %0t", bus.dout, $time);
        end else begin
          e = exp_q.pop_front();
          chk("dout", int'(bus.dout), int'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_status();
    chk("reset_dout", int'(bus.dout), 0);
    chk("reset_dout_valid", int'(bus.dout_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic LIFO
    push_v(8'h11); push_v(8'h22); push_v(8'h33);
    pop_v(0); pop_v(0);

    // Full, overflow, drain, underflow
    cycle(1, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 5; i++) push_v(8'(i));
    for (int i = 0; i < 5; i++) pop_v(0);

    // Stack then replay; third replay pop underflows
    cycle(1, 0, 0, 0, 0, 0, 8'h00);
    push_v(8'hA1); push_v(8'hB2); push_v(8'hC3);
    pop_v(0);
    cycle(0, 1, 0, 0, 0, 0, 8'h00);
    pop_v(1); pop_v(1); pop_v(1);

    // run gating, rewind, push in queue mode
    cycle(1, 0, 0, 0, 0, 0, 8'h00);
    push_v(8'h10); push_v(8'h20);
    cycle(0, 1, 0, 0, 0, 0, 8'h00);
    pop_v(0); pop_v(1);
    cycle(0, 0, 1, 0, 1, 1, 8'h00);
    pop_v(1);
    push_v(8'h99);

    // Top replacement with simultaneous push/pop, including when full
    cycle(1, 0, 0, 0, 0, 0, 8'h00);
    push_v(8'h55); push_v(8'h66);
    cycle(0, 0, 0, 1, 1, 0, 8'h77);
    pop_v(0);
    push_v(8'h01); push_v(8'h02); push_v(8'h03); push_v(8'h04);
    cycle(0, 0, 0, 1, 1, 0, 8'h0F);
    cycle(0, 0, 0, 1, 1, 0, 8'h00);
    cycle(1, 0, 0, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 1, 1, 0, 8'h42);

    // Asynchronous reset mid-replay, then synchronous clear
    cycle(1, 0, 0, 0, 0, 0, 8'h00);
    push_v(8'h05); push_v(8'h06); push_v(8'h07);
    cycle(0, 1, 0, 0, 0, 0, 8'h00);
    pop_v(1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_mode", int'(bus.mode), 0);
    chk("arst_count", int'(bus.count), 0);
    chk("arst_dout_valid", int'(bus.dout_valid), 0);
    chk("arst_dout", int'(bus.dout), 0);
    @(negedge clk);
    rst = 1'b0;
    push_v(8'h0A); push_v(8'h0B);
    cycle(0, 1, 0, 0, 0, 0, 8'h00);
    pop_v(1);
    cycle(1, 0, 0, 0, 0, 0, 8'h00);
    chk("clear_dout", int'(bus.dout), 0);

    // Randomised sessions
    for (int s = 0; s < 25; s++) begin
      cycle(1, 0, 0, 0, 0, 0, 8'h00);
      for (int k = 0; k < int'($urandom_range(0, 12)); k++) begin
        cycle(0, 0, 0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0,
              8'($urandom));
      end
      cycle(0, 1, 0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1, 8'($urandom));
      for (int k = 0; k < 12; k++) begin
        cycle(0, 0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), 8'($urandom));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reads_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/path_stack_queue.md
Name: path_stack_queue

Overview:
Parametrised LIFO/FIFO path store for the maze solver. During search it acts as a stack that holds the current path. After the solver asserts done, it switches to queue mode and replays the surviving path from oldest to newest entry. This generation adds the following over the fixed 8-bit/256-entry version:
- configurable width and depth
- full/empty/count status
- sticky overflow/underflow error flags
- a registered output with a valid strobe
- non-destructive replay with rewind
- a synchronous soft clear

Parameters:
DATA_W, 8, width of one location word ({x[DATA_W/2-1:0], y[DATA_W/2-1:0]} in the maze)
DEPTH, 256, number of entries; any value >= 2 (not required to be a power of two)
CNT_W, $clog2(DEPTH+1), width of count and pointers (derived; must not be overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous soft reset of pointers, mode and flags
push  input  1  write din (stack mode only)
pop  input  1  read request (stack: remove top; queue: next replay entry, qualified by run)
run  input  1  replay enable; queue-mode pops are ignored while low
done  input  1  one-cycle strobe; enter queue mode and start replay at entry 0
rewind  input  1  queue mode: restart replay at entry 0
din  input  DATA_W  location to push
dout  output  DATA_W  registered read data
dout_valid  output  1  one-cycle strobe, dout updated this cycle
mode  output  1  0 = STACK, 1 = QUEUE
count  output  CNT_W  entries currently stored
empty  output  1  stack: count==0; queue: rd_ptr==count
full  output  1  count==DEPTH
overflow  output  1  sticky: push attempted while full or in queue mode
underflow  output  1  sticky: accepted-type pop attempted while empty

Behaviour:
- Reset (rst high, asynchronous) clears the following; memory contents are not cleared:
  - count=0, rd_ptr=0, mode=STACK
  - dout=0, dout_valid=0, overflow=0, underflow=0
- Priority each edge: clear > done > rewind > push/pop. clear has the same effect as rst, but synchronous.
- dout_valid defaults to 0 every cycle. It is 1 only in the cycle after an accepted pop, with dout holding the read word.
- empty, full and count are combinational from registered state (zero latency).
- STACK mode:
  - push && !full: mem[count] <= din, count+1.
  - push && full: ignored, overflow <= 1.
  - pop && !empty: dout <= mem[count-1], count-1, dout_valid next cycle.
  - pop && empty: ignored, underflow <= 1.
  - push && pop same cycle, count>0: dout <= mem[count-1], mem[count-1] <= din, count unchanged, dout_valid=1 (top replaced).
  - push && pop same cycle, count==0: push accepted, pop flagged as underflow.
- done (either mode): mode <= QUEUE, rd_ptr <= 0, count frozen. A push or pop in the same cycle is ignored.
- QUEUE mode:
  - pop && run && rd_ptr<count: dout <= mem[rd_ptr], rd_ptr+1, dout_valid=1.
  - pop && run && empty: underflow <= 1.
  - pop && !run: ignored, no flag.
  - push: ignored, overflow <= 1.
  - rewind: rd_ptr <= 0, and any pop that cycle is ignored.
  - Replay is non-destructive: count is unchanged by pops.
- Leaving QUEUE mode is only possible through clear or rst.
- Pointer arithmetic is in CNT_W bits, so there is no wrap-around. Pointers saturate by construction because of the full/empty guards.
- rst asserted mid-operation takes effect immediately. Outputs return to reset values without waiting for a clock edge.

Decomposition:
- Shared package stq_pkg:
  - MODE_STACK=1'b0, MODE_QUEUE=1'b1
  - helper function for CNT_W
- One sub-module, stq_mem:
  - DEPTH x DATA_W, synchronous write, combinational read port
  - the read port feeds the dout register in the parent
- Control, pointers and flags live in path_stack_queue.

Test Plan:
All scenarios use DATA_W=8, DEPTH=4.
1. Reset, then push 0x11,0x22,0x33 -> count=3, empty=0. Pop twice -> dout 0x33 then 0x22, one dout_valid each, count=1.
2. Push 0x01..0x04 -> full=1. Push 0x05 -> overflow=1, count=4, top still 0x04. Pop on empty stack after draining -> underflow=1.
3. Push 0xA1,0xB2,0xC3. Pop (removes 0xC3). done, run=1, pop x3 -> dout 0xA1, 0xB2, then underflow=1 with empty=1. Count stays 2.
4. Queue mode with entries 0x10,0x20: pop with run=0 -> no dout_valid. Pop with run=1 -> 0x10. rewind, then pop -> 0x10 again. Push -> overflow=1.
5. Stack holds 0x55,0x66. push=1, pop=1, din=0x77 same cycle -> dout=0x66, count=2. Next pop -> 0x77.
6. Assert rst asynchronously between edges during queue replay -> mode=0, count=0, dout_valid=0 immediately. clear in a later session -> same state on the next edge.
